// File: rtl/transport_pkg.sv
// Shared transport-layer constants and the receive FSM state type.
// Header bytes and cmd tags must stay in sync with the transmit-side packetizer.
package transport_pkg;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;
  localparam logic [7:0] TRAILER   = 8'hFF;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_HI,
    ST_CTRL_LO,
    ST_CTRL_PAD,
    ST_AUD_HI,
    ST_AUD_LO,
    ST_AUD_TRAIL,
    ST_DISCARD
  } rxState_t;

endpackage

// File: rtl/transport_receive_if.sv
// Byte-in / word-out link between the phone-link byte source and the receive transport.
// master drives bytes and consumes words; slave is the transport_receive block.
interface transport_receive_if;
  logic [7:0]  packetIn;
  logic        byteValid;
  logic [1:0]  cmd;
  logic [15:0] data;
  logic        dataValid;

  modport master (output packetIn, byteValid, input cmd, data, dataValid);
  modport slave  (input packetIn, byteValid, output cmd, data, dataValid);
endinterface

// File: rtl/transport_word_assembler.sv
// Big-endian byte-pair to 16-bit word assembler with a registered one-cycle strobe.
// clear drops a half-received word when the FSM leaves a packet.
module transport_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        loadHi,
  input  logic        loadLo,
  input  logic [7:0]  byteIn,
  output logic [15:0] word,
  output logic        wordStrobe
);

  logic [7:0]  hiReg;
  logic [15:0] wordReg;
  logic        strobeReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiReg     <= 8'h00;
      wordReg   <= 16'h0000;
      strobeReg <= 1'b0;
    end else begin
      strobeReg <= loadLo;
      if (loadLo)
        wordReg <= {hiReg, byteIn};
      // loadLo above sees the old hiReg, so a same-cycle clear is safe
      if (clear)
        hiReg <= 8'h00;
      else if (loadHi)
        hiReg <= byteIn;
    end
  end

  assign word       = wordReg;
  assign wordStrobe = strobeReg;

endmodule

// File: rtl/transport_receive.sv
// Receive-side transport: header decode, word reassembly, packet error/count tracking.
// Optional: define TRANSPORT_RECEIVE_STRICT_PAD_EN to hold control words until padding is verified as zero.
module transport_receive
  import transport_pkg::*;
#(
  parameter int packetSize = 16
) (
  input  logic                clk,
  input  logic                reset,
  transport_receive_if.slave  link,
  output logic                busy,
  output logic                packetError,
  output logic [7:0]          packetCount
);

  localparam int CW = $clog2(packetSize) + 1;
  localparam logic [CW-1:0] LOAD = CW'(packetSize - 1);

  rxState_t      state;
  logic [CW-1:0] byteCount;
  logic          errorReg;
  logic [7:0]    countReg;
  logic [1:0]    tagReg;

  logic          asmClear;
  logic          asmLoadHi;
  logic          asmLoadLo;
  logic [7:0]    asmByte;
  logic [1:0]    lsbTag;
  logic [15:0]   asmWord;
  logic          asmStrobe;
  logic          lastByte;

  assign lastByte = (byteCount == CW'(1));

`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
  logic [7:0] ctrlLo;
  logic       padOk;
  logic       padGood;
  assign padGood = padOk && (link.packetIn == 8'h00);
`endif

  always_comb begin
    asmClear  = 1'b0;
    asmLoadHi = 1'b0;
    asmLoadLo = 1'b0;
    asmByte   = link.packetIn;
    lsbTag    = CMD_IDLE;
    if (link.byteValid) begin
      case (state)
        ST_CTRL_HI: asmLoadHi = 1'b1;
        ST_CTRL_LO: begin
`ifndef TRANSPORT_RECEIVE_STRICT_PAD_EN
          asmLoadLo = 1'b1;
          lsbTag    = CMD_CTRL;
`endif
        end
        ST_CTRL_PAD: begin
          if (lastByte) begin
            asmClear = 1'b1;
`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
            // replay the held low byte so the word leaves one cycle after the last pad
            if (padGood) begin
              asmLoadLo = 1'b1;
              asmByte   = ctrlLo;
              lsbTag    = CMD_CTRL;
            end
`endif
          end
        end
        ST_AUD_HI: asmLoadHi = 1'b1;
        ST_AUD_LO: begin
          asmLoadLo = 1'b1;
          lsbTag    = CMD_AUDIO;
        end
        ST_AUD_TRAIL: asmClear = 1'b1;
        ST_DISCARD:   asmClear = lastByte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      byteCount <= '0;
      errorReg  <= 1'b0;
      countReg  <= 8'h00;
      tagReg    <= CMD_IDLE;
`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
      ctrlLo    <= 8'h00;
      padOk     <= 1'b0;
`endif
    end else begin
      errorReg <= 1'b0;
      if (asmLoadLo)
        tagReg <= lsbTag;
      if (link.byteValid) begin
        if (state != ST_IDLE)
          byteCount <= byteCount - CW'(1);
        case (state)
          ST_IDLE: begin
            byteCount <= LOAD;
            if (link.packetIn == HDR_CTRL)
              state <= ST_CTRL_HI;
            else if (link.packetIn == HDR_AUDIO)
              state <= ST_AUD_HI;
            else begin
              state    <= ST_DISCARD;
              errorReg <= 1'b1;
            end
          end
          ST_CTRL_HI: state <= ST_CTRL_LO;
          ST_CTRL_LO: begin
            state <= ST_CTRL_PAD;
`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
            ctrlLo <= link.packetIn;
            padOk  <= 1'b1;
`endif
          end
          ST_CTRL_PAD: begin
`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
            if (link.packetIn != 8'h00)
              padOk <= 1'b0;
            if (lastByte) begin
              state <= ST_IDLE;
              if (padGood)
                countReg <= countReg + 8'd1;
              else
                errorReg <= 1'b1;
            end
`else
            if (lastByte) begin
              state    <= ST_IDLE;
              countReg <= countReg + 8'd1;
            end
`endif
          end
          ST_AUD_HI: state <= ST_AUD_LO;
          // two bytes left means only the trailer remains after this sample
          ST_AUD_LO: state <= (byteCount == CW'(2)) ? ST_AUD_TRAIL : ST_AUD_HI;
          ST_AUD_TRAIL: begin
            state <= ST_IDLE;
            if (link.packetIn == TRAILER)
              countReg <= countReg + 8'd1;
            else
              errorReg <= 1'b1;
          end
          ST_DISCARD: begin
            if (lastByte)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  transport_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asmClear),
    .loadHi     (asmLoadHi),
    .loadLo     (asmLoadLo),
    .byteIn     (asmByte),
    .word       (asmWord),
    .wordStrobe (asmStrobe)
  );

  assign link.data      = asmWord;
  assign link.dataValid = asmStrobe;
  assign link.cmd       = (state == ST_IDLE && !asmStrobe) ? CMD_IDLE : tagReg;
  assign busy           = (state != ST_IDLE);
  assign packetError    = errorReg;
  assign packetCount    = countReg;

endmodule

// File: tb/tb_transport_receive.sv
// Scoreboard bench for transport_receive: directed packets push expected words/errors,
// a negedge monitor pops and compares every dataValid and packetError strobe.
module tb_transport_receive;
  import transport_pkg::*;

  localparam int PS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic       packetError;
  logic [7:0] packetCount;

  transport_receive_if link();

  transport_receive #(.packetSize(PS)) dut (
    .clk         (clk),
    .reset       (reset),
    .link        (link),
    .busy        (busy),
    .packetError (packetError),
    .packetCount (packetCount)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          errPending = 0;
  int          expCount = 0;
  logic [17:0] expQ[$];
  logic [15:0] samples [7] = '{16'hAABB, 16'hCCDD, 16'hEE11, 16'h2233,
                               16'h4455, 16'h6677, 16'h8899};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expWord(input logic [1:0] c, input logic [15:0] w);
    expQ.push_back({c, w});
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    link.byteValid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    link.packetIn  = b;
    link.byteValid = 1'b1;
    @(posedge clk);
    #1;
    link.byteValid = 1'b0;
  endtask

  task automatic idle(input int n);
    link.byteValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // control packet whose padding is zero except padVal at padIdx
  task automatic sendCtrl(input logic [15:0] w, input int padIdx, input logic [7:0] padVal);
    sendByte(HDR_CTRL, 0);
    sendByte(w[15:8], 0);
    sendByte(w[7:0], 0);
    for (int i = 3; i < PS; i++)
      sendByte((i == padIdx) ? padVal : 8'h00, 0);
  endtask

  task automatic sendAudio(input logic [7:0] trailer, input int maxGap);
    sendByte(HDR_AUDIO, $urandom_range(0, maxGap));
    for (int i = 0; i < 7; i++) begin
      sendByte(samples[i][15:8], $urandom_range(0, maxGap));
      sendByte(samples[i][7:0], $urandom_range(0, maxGap));
    end
    sendByte(trailer, $urandom_range(0, maxGap));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (link.dataValid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got cmd=%0h data=%0h, none expected", link.cmd, link.data);
        end else begin
          check("word", 32'({link.cmd, link.data}), 32'(expQ[0]));
          void'(expQ.pop_front());
        end
      end
      if (packetError) begin
        check("err_with_valid", 32'(link.dataValid), 32'd0);
        checks++;
        if (errPending == 0) begin
          failures++;
          $display("FAIL unexpected_error: got packetError=1 expected 0");
        end else
          errPending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    link.packetIn  = 8'h00;
    link.byteValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", 32'(link.cmd), 32'd0);
    check("rst_data", 32'(link.data), 32'd0);
    check("rst_valid", 32'(link.dataValid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(packetError), 32'd0);
    check("rst_count", 32'(packetCount), 32'd0);
    reset = 1'b0;
    idle(1);

    // good control packet
    expWord(CMD_CTRL, 16'h1234);
    expCount++;
    sendByte(HDR_CTRL, 0);
    check("busy_after_hdr", 32'(busy), 32'd1);
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    for (int i = 3; i < PS; i++) sendByte(8'h00, 0);
    check("busy_after_last", 32'(busy), 32'd0);
    idle(3);
    check("count_ctrl", 32'(packetCount), 32'(expCount));
    check("cmd_idle", 32'(link.cmd), 32'(CMD_IDLE));

    // good audio packet
    for (int i = 0; i < 7; i++) expWord(CMD_AUDIO, samples[i]);
    expCount++;
    sendAudio(TRAILER, 0);
    idle(3);
    check("count_audio", 32'(packetCount), 32'(expCount));

    // audio packet with bad trailer: samples stand, error at the trailer
    for (int i = 0; i < 7; i++) expWord(CMD_AUDIO, samples[i]);
    errPending++;
    sendAudio(8'h7F, 0);
    idle(3);
    check("count_bad_trailer", 32'(packetCount), 32'(expCount));

    // bad header, 15 swallowed bytes (some look like headers), then a control packet back-to-back
    errPending++;
    sendByte(8'h33, 0);
    for (int i = 0; i < PS - 1; i++)
      sendByte((i == 0) ? HDR_CTRL : ((i == 5) ? HDR_AUDIO : 8'(i * 17)), 0);
    check("busy_after_discard", 32'(busy), 32'd0);
    expWord(CMD_CTRL, 16'h5678);
    expCount++;
    sendCtrl(16'h5678, -1, 8'h00);
    idle(3);
    check("count_after_discard", 32'(packetCount), 32'(expCount));

    // non-zero padding byte
`ifdef TRANSPORT_RECEIVE_STRICT_PAD_EN
    errPending++;
`else
    expWord(CMD_CTRL, 16'h1234);
    expCount++;
`endif
    sendCtrl(16'h1234, 7, 8'h01);
    idle(3);
    check("count_pad", 32'(packetCount), 32'(expCount));
    check("queue_mid", 32'(expQ.size()), 32'd0);

    // reset after the 5th byte: the two samples already strobed appear, the rest is dropped
    expWord(CMD_AUDIO, samples[0]);
    expWord(CMD_AUDIO, samples[1]);
    sendByte(HDR_AUDIO, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    sendByte(8'hCC, 0);
    sendByte(8'hDD, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(packetCount), 32'd0);
    check("midrst_valid", 32'(link.dataValid), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 7; i++) expWord(CMD_AUDIO, samples[i]);
    sendAudio(TRAILER, 3);
    idle(4);
    check("count_resend", 32'(packetCount), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("queue_empty", 32'(expQ.size()), 32'd0);
    check("errors_seen", 32'(errPending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
